// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv
// ----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__aoi21_bist
// Built-in self test for an aoi21 standard cell (ZN = ~((A1 & A2) | B)).
// An 8-bit LFSR produces PATTERNS three-bit stimulus vectors. Each response
// is registered together with its golden value and compared one edge later.
// Mismatches are counted in a saturating 8-bit counter.
//
// Optional feature: define GF180MCU_AOI21_BIST_MISR_EN to compress every
// ZN sample into a 16-bit CRC-CCITT MISR on SIG. Without the macro, SIG is
// tied to zero and no MISR logic is built.
//
// Run timeline (edge 0 = START edge):
//   edge 0        : load, drive pattern 0, enter RUN
//   edge k        : drive pattern k (k = 1 .. PATTERNS-1)
//   edge k+1      : capture ZN/golden for pattern k
//   edge k+2      : accumulate compare of pattern k
//   edge PATTERNS : RUN -> LAST (last capture)
//   edge P+1      : LAST -> FIN, final accumulate, DONE rises
// ----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__aoi21_bist #(
  parameter int unsigned PATTERNS = 64,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic        CLK,
  input  logic        RN,
  input  logic        START,
  output logic        A1,
  output logic        A2,
  output logic        B,
  input  logic        ZN,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [7:0]  ERR_CNT,
  output logic [15:0] SIG,
  inout  wire         VDD,
  inout  wire         VSS
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [9:0] LAST_IDX = 10'(PATTERNS - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Golden model of the cell; pat = {B, A2, A1}.
  function automatic logic aoi21(input logic [2:0] pat);
    return ~((pat[0] & pat[1]) | pat[2]);
  endfunction

  state_t      state_r, state_nxt;
  logic [7:0]  lfsr_r, lfsr_nxt;
  logic [9:0]  cnt_r, cnt_nxt;
  logic [2:0]  pat_r, pat_nxt;
  logic        zn_r, zn_nxt;
  logic        exp_r, exp_nxt;
  logic        cmp_valid_r, cmp_valid_nxt;
  logic        busy_r, busy_nxt;
  logic        done_r, done_nxt;
  logic        pass_r, pass_nxt;
  logic [7:0]  err_r, err_nxt;
  logic [7:0]  err_acc;
  logic        accumulate;

`ifdef GF180MCU_AOI21_BIST_MISR_EN
  // CRC-CCITT MISR step: x^16+x^12+x^5+1, shift left, input = zn ^ s[15].
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic zn);
    return {s[14:0], 1'b0} ^ ((zn ^ s[15]) ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0] sig_r, sig_nxt;
  logic [15:0] sig_acc;
`endif

  // Comparison of the previously captured sample happens in LAST and in RUN
  // once the first capture has been made.
  assign accumulate = (state_r == LAST) || ((state_r == RUN) && cmp_valid_r);
  assign err_acc    = (accumulate && (zn_r != exp_r) && (err_r != 8'hFF))
                      ? (err_r + 8'd1) : err_r;
`ifdef GF180MCU_AOI21_BIST_MISR_EN
  assign sig_acc    = accumulate ? misr_step(sig_r, zn_r) : sig_r;
`endif

  // State register: asynchronous abort back to IDLE.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; START only matters in IDLE and FIN.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE, FIN: begin
        if (START) begin
          state_nxt = RUN;
        end else begin
          state_nxt = state_r;
        end
      end
      RUN: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt = LAST;
        end else begin
          state_nxt = RUN;
        end
      end
      LAST:    state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values for every registered output.
  always_comb begin
    lfsr_nxt      = lfsr_r;
    cnt_nxt       = cnt_r;
    pat_nxt       = pat_r;
    zn_nxt        = zn_r;
    exp_nxt       = exp_r;
    cmp_valid_nxt = cmp_valid_r;
    done_nxt      = done_r;
    pass_nxt      = pass_r;
    err_nxt       = err_r;
`ifdef GF180MCU_AOI21_BIST_MISR_EN
    sig_nxt       = sig_r;
`endif
    busy_nxt      = (state_nxt == RUN) || (state_nxt == LAST);
    case (state_r)
      IDLE, FIN: begin
        if (START) begin
          lfsr_nxt      = lfsr_adv(SEED_EFF);
          cnt_nxt       = 10'd0;
          pat_nxt       = SEED_EFF[2:0];
          cmp_valid_nxt = 1'b0;
          done_nxt      = 1'b0;
          pass_nxt      = 1'b0;
          err_nxt       = 8'd0;
`ifdef GF180MCU_AOI21_BIST_MISR_EN
          sig_nxt       = 16'hFFFF;
`endif
        end else begin
          pat_nxt       = 3'b000;
        end
      end
      RUN: begin
        // Capture the response to the pattern currently on the cell.
        zn_nxt        = ZN;
        exp_nxt       = aoi21(pat_r);
        cmp_valid_nxt = 1'b1;
        err_nxt       = err_acc;
`ifdef GF180MCU_AOI21_BIST_MISR_EN
        sig_nxt       = sig_acc;
`endif
        if (cnt_r != LAST_IDX) begin
          pat_nxt  = lfsr_r[2:0];
          lfsr_nxt = lfsr_adv(lfsr_r);
          cnt_nxt  = cnt_r + 10'd1;
        end else begin
          pat_nxt  = pat_r;
        end
      end
      LAST: begin
        err_nxt       = err_acc;
`ifdef GF180MCU_AOI21_BIST_MISR_EN
        sig_nxt       = sig_acc;
`endif
        pat_nxt       = 3'b000;
        cmp_valid_nxt = 1'b0;
        done_nxt      = 1'b1;
        pass_nxt      = (err_acc == 8'd0);
      end
      default: begin
        pat_nxt       = 3'b000;
      end
    endcase
  end

  // Datapath registers; reset clears every trace of an aborted run.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      lfsr_r      <= SEED_EFF;
      cnt_r       <= 10'd0;
      pat_r       <= 3'b000;
      zn_r        <= 1'b0;
      exp_r       <= 1'b0;
      cmp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_r       <= 8'd0;
    end else begin
      lfsr_r      <= lfsr_nxt;
      cnt_r       <= cnt_nxt;
      pat_r       <= pat_nxt;
      zn_r        <= zn_nxt;
      exp_r       <= exp_nxt;
      cmp_valid_r <= cmp_valid_nxt;
      busy_r      <= busy_nxt;
      done_r      <= done_nxt;
      pass_r      <= pass_nxt;
      err_r       <= err_nxt;
    end
  end

`ifdef GF180MCU_AOI21_BIST_MISR_EN
  // Signature register, zero in reset and preset to all-ones at run start.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sig_r <= 16'h0000;
    end else begin
      sig_r <= sig_nxt;
    end
  end

  assign SIG = sig_r;
`else
  assign SIG = 16'h0000;
`endif

  assign A1      = pat_r[0];
  assign A2      = pat_r[1];
  assign B       = pat_r[2];
  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign PASS    = pass_r;
  assign ERR_CNT = err_r;

endmodule
